// File: rtl/seven_segment_scanner.sv
// Multiplexed hex display scanner: double-buffered value, one digit per refresh period.
// Optional leading-zero blanking is enabled by defining SEVEN_SEGMENT_BLANK_LEADING_ZEROS_EN.
module seven_segment_scanner #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 25000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  output logic                  pending,
  output logic [3:0]            binary,
  output logic                  dp,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  blank,
  output logic                  frame_start
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  logic [CW-1:0]         count_reg;
  logic [IW-1:0]         idx_reg;
  logic [4*DIGITS-1:0]   shadow_reg, active_reg;
  logic [DIGITS-1:0]     shadow_dp_reg, active_dp_reg;
  logic                  pending_reg;
  logic [3:0]            binary_reg;
  logic                  dp_reg;
  logic [DIGITS-1:0]     digit_en_reg;
  logic                  frame_start_reg;

  logic                  tick, wrap;
  logic [IW-1:0]         idx_next;
  logic [4*DIGITS-1:0]   disp_value;
  logic [DIGITS-1:0]     disp_dp;
  logic [3:0]            nibble [DIGITS];

  assign tick     = (count_reg == CNT_MAX);
  assign wrap     = tick && (idx_reg == IDX_MAX);
  assign idx_next = wrap ? '0 : (tick ? idx_reg + 1'b1 : idx_reg);

  // Data digit 0 sees on a wrap edge: a coincident load beats the shadow.
  always_comb begin
    disp_value = active_reg;
    disp_dp    = active_dp_reg;
    if (wrap && load) begin
      disp_value = value;
      disp_dp    = dp_in;
    end else if (wrap && pending_reg) begin
      disp_value = shadow_reg;
      disp_dp    = shadow_dp_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_nib
      assign nibble[gi] = disp_value[4*gi +: 4];
    end
  endgenerate

`ifdef SEVEN_SEGMENT_BLANK_LEADING_ZEROS_EN
  logic [DIGITS-1:0] blank_vec;
  logic              blank_reg;

  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_blank
      if (gi == 0) begin : g_first
        assign blank_vec[gi] = 1'b0;
      end else begin : g_upper
        assign blank_vec[gi] = ~|disp_value[4*DIGITS-1:4*gi] & ~disp_dp[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blank_reg <= 1'b0;
    end else if (tick) begin
      blank_reg <= blank_vec[idx_next];
    end
  end

  assign blank = blank_reg;
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg       <= '0;
      idx_reg         <= '0;
      shadow_reg      <= '0;
      shadow_dp_reg   <= '0;
      active_reg      <= '0;
      active_dp_reg   <= '0;
      pending_reg     <= 1'b0;
      binary_reg      <= '0;
      dp_reg          <= 1'b0;
      digit_en_reg    <= DIGITS'(1);
      frame_start_reg <= 1'b0;
    end else begin
      count_reg       <= tick ? '0 : count_reg + 1'b1;
      idx_reg         <= idx_next;
      frame_start_reg <= wrap;
      if (load) begin
        shadow_reg    <= value;
        shadow_dp_reg <= dp_in;
      end
      if (wrap) begin
        active_reg    <= disp_value;
        active_dp_reg <= disp_dp;
        pending_reg   <= 1'b0;
      end else if (load) begin
        pending_reg   <= 1'b1;
      end
      if (tick) begin
        binary_reg   <= nibble[idx_next];
        dp_reg       <= disp_dp[idx_next];
        digit_en_reg <= DIGITS'(1) << idx_next;
      end
    end
  end

  assign pending     = pending_reg;
  assign binary      = binary_reg;
  assign dp          = dp_reg;
  assign digit_en    = digit_en_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Randomized bench for seven_segment_scanner against an edge-count based display model.
module tb_seven_segment_scanner;
  localparam int D    = 4;
  localparam int RD   = 4;
  localparam int NCYC = 700;

  logic           clk = 1'b0;
  logic           rst;
  logic [4*D-1:0] value;
  logic [D-1:0]   dp_in;
  logic           load;
  logic           pending;
  logic [3:0]     binary;
  logic           dp;
  logic [D-1:0]   digit_en;
  logic           blank;
  logic           frame_start;

  seven_segment_scanner #(.DIGITS(D), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
    .pending(pending), .binary(binary), .dp(dp), .digit_en(digit_en),
    .blank(blank), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: n edges since reset; shown digit is (n/RD)%D, frames wrap every D*RD edges.
  int             n;
  logic [4*D-1:0] shown, shadow;
  logic [D-1:0]   shown_dp, shadow_dp;
  bit             pend, fs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, got, exp, n);
    end
  endtask

  task automatic model_reset();
    n = 0; shown = '0; shadow = '0; shown_dp = '0; shadow_dp = '0; pend = 0; fs = 0;
  endtask

  task automatic model_edge(input bit ld, input logic [4*D-1:0] v, input logic [D-1:0] dv);
    n++;
    fs = (n % (D*RD)) == 0;
    if (fs) begin
      if (ld) begin
        shown = v; shown_dp = dv;
      end else if (pend) begin
        shown = shadow; shown_dp = shadow_dp;
      end
      pend = 0;
    end else if (ld) begin
      shadow = v; shadow_dp = dv; pend = 1;
    end
  endtask

  task automatic check_outputs();
    int dig;
    logic [3:0] nib;
    logic [D-1:0] en;
    bit bl;
    dig = (n / RD) % D;
    nib = 4'((shown >> (4*dig)) & 16'hF);
    en  = D'(1) << dig;
    bl  = 0;
`ifdef SEVEN_SEGMENT_BLANK_LEADING_ZEROS_EN
    bl = (dig != 0) && ((shown >> (4*dig)) == 0) && !shown_dp[dig];
`endif
    check("digit_en", 32'(digit_en), 32'(en));
    check("binary", 32'(binary), 32'(nib));
    check("dp", 32'(dp), 32'(shown_dp[dig]));
    check("pending", 32'(pending), 32'(pend));
    check("frame_start", 32'(frame_start), 32'(fs));
    check("blank", 32'(blank), 32'(bl));
  endtask

  initial begin
    bit did9, did_rst;
    rst = 1'b1; load = 1'b0; value = '0; dp_in = '0;
    model_reset();
    did9 = 0; did_rst = 0;
    repeat (2) @(negedge clk);
    check_outputs();
    rst = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      check_outputs();
      load = 1'b0;
      value = 16'($urandom);
      dp_in = 4'($urandom);
      if (c == 5) begin
        load = 1'b1; value = 16'h1234; dp_in = 4'b0000;
      end else if (c == 20) begin
        load = 1'b1; value = 16'hABCD;
      end else if (c == 23) begin
        load = 1'b1; value = 16'h5678;
      end else if (!did9 && c >= 56 && ((n + 1) % (D*RD)) == 0) begin
        load = 1'b1; value = 16'h9999; did9 = 1;
      end else if (c >= 290 && !did_rst && !pend && ((n + 1) % (D*RD)) != 0) begin
        load = 1'b1;
      end else if (c >= 80) begin
        load = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 3) == 0) value = 16'h00FF & value;
      end
      @(posedge clk);
      model_edge(load, value, dp_in);
      if (!did_rst && c >= 300 && pend && ((n / RD) % D) == 2) begin
        #2 rst = 1'b1;
        load = 1'b0;
        #1;
        model_reset();
        check("rst_digit_en", 32'(digit_en), 32'd1);
        check("rst_binary", 32'(binary), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        did_rst = 1;
      end else begin
        @(negedge clk);
      end
    end
    check("directed_9999_hit", 32'(did9), 32'd1);
    check("directed_reset_hit", 32'(did_rst), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
- Upstream stage of the 4-bit-to-segment decoder. Holds a multi-digit hex value and time-multiplexes it onto a shared display.
- Each digit period, presents one nibble on `binary` to the decoder and drives the matching one-hot digit enable.
- New values are double-buffered and committed only at frame boundaries, so a refresh never shows a mix of old and new digits.

Parameters:
- DIGITS, 4: number of multiplexed digits; legal range ≥2.
- REFRESH_DIV, 25000: clock cycles per digit period; legal range ≥1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- value  in  4*DIGITS  digit nibbles; nibble i = value[4i+3:4i]; digit 0 is least significant
- dp_in  in  DIGITS  decimal-point request per digit
- load  in  1  1-cycle strobe; captures value/dp_in into the shadow buffer
- pending  out  1  shadow holds a value not yet committed to display
- binary  out  4  nibble for the current digit, to the decoder's binary input
- dp  out  1  decimal point for the current digit
- digit_en  out  DIGITS  one-hot digit enable, active-high
- blank  out  1  downstream gates all segments off when 1
- frame_start  out  1  1-cycle pulse when digit 0 becomes active

Behaviour:
- Clock/reset: one clock `clk`; `rst` is asynchronous and active-high.
- Reset values: prescaler=0, idx=0, active=0, shadow=0, pending=0, binary=0, dp=0, digit_en=1 (digit 0), blank=0, frame_start=0.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps. tick=1 in the cycle where count==REFRESH_DIV-1. With REFRESH_DIV=1, tick=1 every cycle.
- Digit index: on a tick edge, idx advances to (idx+1) mod DIGITS; DIGITS-1 wraps to 0.
- Outputs: binary, dp, digit_en and blank are registered and change on the same edge as idx. No combinational path from inputs to outputs.
- Digit period: every digit is shown for exactly REFRESH_DIV cycles. A frame is DIGITS*REFRESH_DIV cycles.
- Load: when load=1, shadow<=value, shadow_dp<=dp_in, pending<=1. A repeated load before commit overwrites the shadow (last load wins).
- Commit: on the tick edge where idx wraps DIGITS-1→0:
  - if pending: active<=shadow, pending<=0;
  - digit 0's outputs on that same edge use the newly committed data.
- Load coincident with commit edge: the incoming value/dp_in go straight to active and to digit 0's outputs; pending=0.
- frame_start: 1 for the one cycle after every wrap edge, whether or not a commit occurred.
- A value loaded mid-frame appears from the next frame's digit 0. Worst-case load-to-display latency is DIGITS*REFRESH_DIV cycles.
- Reset mid-frame: asynchronous reset returns all state to reset values immediately, including discarding pending data and the shadow. Scanning restarts at digit 0 with a full REFRESH_DIV period.

Optional Feature:
- Macro: SEVEN_SEGMENT_BLANK_LEADING_ZEROS_EN.
- Defined: leading-zero blanking is enabled.
  - blank=1 for digit i when i≠0, active nibble i==0, all more significant nibbles ==0, and active dp for i ==0.
  - Digit 0 is never blanked.
  - blank is registered with the other outputs and evaluated on the committed data.
- Undefined: blank is constant 0 and no blanking logic is synthesized.

Test Plan (DIGITS=4, REFRESH_DIV=4):
- Reset, no load → digit_en steps 0001→0010→0100→1000→0001 every 4 cycles, binary=0, frame_start pulses every 16 cycles.
- load with value=0x1234 mid-frame → pending=1 until the next wrap. Then binary sequence is 4,3,2,1 with matching digit_en, and pending=0.
- load with 0xABCD then 0x5678 within one frame → only 0x5678 is displayed; 0xABCD never appears.
- load with 0x9999 on the exact wrap edge → digit 0 shows 9 on that edge and pending stays 0.
- Assert rst during digit 2 with a load pending → next cycle has digit_en=0001, binary=0 and pending=0, and the first period lasts 4 cycles.
- Macro defined, value=0x0050, dp_in=0 → blank=1 on digits 3 and 2 and 0 on digits 1 and 0. With dp_in=0100, digit 2 is unblanked.
